// File: rtl/gpio_input_ctrl_pkg.sv
// Shared definitions for the GPIO input controller: bus width, register map
// and the debounce counter sizing helper.
package gpio_input_ctrl_pkg;

    localparam int BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        GPIO_ADDR_DATA = 2'd0,
        GPIO_ADDR_RISE = 2'd1,
        GPIO_ADDR_FALL = 2'd2,
        GPIO_ADDR_PEND = 2'd3
    } gpio_addr_e;

    // A single-cycle debounce still needs one counter bit to stay well formed.
    function automatic int debounce_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO pin: two-flop synchronizer, saturating debounce counter and the
// accepted (stable) level, plus one-cycle strobes for the accepted transition.
module gpio_debounce
    import gpio_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic resetN,
    input  logic pin,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    // The strobes fire in the cycle before stable flips, so pending bits
    // update on the same edge as stable.
    assign accept = (sync2 != stable) && (cnt == CNT_LAST);
    assign rise   = accept & sync2;
    assign fall   = accept & ~sync2;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (accept) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_input_ctrl.sv
// GPIO input controller: debounced pin levels, edge-triggered pending bits
// and a 4-word bus slave with a one-cycle registered response.
module gpio_input_ctrl
    import gpio_input_ctrl_pkg::*;
#(
    parameter int PIN_COUNT       = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [PIN_COUNT-1:0] GPIOIn,
    input  logic                 cs,
    input  logic                 as,
    input  logic                 rw,
    input  logic [1:0]           addr,
    input  logic [BUS_WIDTH-1:0] wrData,
    output logic [BUS_WIDTH-1:0] rdData,
    output logic                 rdy,
    output logic                 irq
);

    logic [PIN_COUNT-1:0] stable;
    logic [PIN_COUNT-1:0] rise_hit;
    logic [PIN_COUNT-1:0] fall_hit;
    logic [PIN_COUNT-1:0] rise_en;
    logic [PIN_COUNT-1:0] fall_en;
    logic [PIN_COUNT-1:0] pend;
    logic [PIN_COUNT-1:0] wr_pins;
    logic [PIN_COUNT-1:0] set_mask;
    logic [PIN_COUNT-1:0] clr_mask;
    logic [BUS_WIDTH-1:0] rd_word;
    logic                 access;
    logic                 wr_access;

    for (genvar i = 0; i < PIN_COUNT; i++) begin : g_pin
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .resetN(resetN),
            .pin   (GPIOIn[i]),
            .stable(stable[i]),
            .rise  (rise_hit[i]),
            .fall  (fall_hit[i])
        );
    end

    if (PIN_COUNT < BUS_WIDTH) begin : g_unused
        logic unused_wr_hi;
        assign unused_wr_hi = ^wrData[BUS_WIDTH-1:PIN_COUNT];
    end

    assign access    = cs & as;
    assign wr_access = access & ~rw;
    assign wr_pins   = wrData[PIN_COUNT-1:0];
    assign set_mask  = (rise_hit & rise_en) | (fall_hit & fall_en);
    assign clr_mask  = (wr_access && addr == GPIO_ADDR_PEND) ? wr_pins : '0;
    assign irq       = |pend;

    always_comb begin
        rd_word = '0;
        case (gpio_addr_e'(addr))
            GPIO_ADDR_DATA: rd_word[PIN_COUNT-1:0] = stable;
            GPIO_ADDR_RISE: rd_word[PIN_COUNT-1:0] = rise_en;
            GPIO_ADDR_FALL: rd_word[PIN_COUNT-1:0] = fall_en;
            GPIO_ADDR_PEND: rd_word[PIN_COUNT-1:0] = pend;
            default:        rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rise_en <= '0;
            fall_en <= '0;
        end else if (wr_access) begin
            if (addr == GPIO_ADDR_RISE) rise_en <= wr_pins;
            if (addr == GPIO_ADDR_FALL) fall_en <= wr_pins;
        end
    end

    // A new edge in the same cycle as its write-1-to-clear keeps the bit set.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rdy    <= 1'b0;
            rdData <= '0;
        end else begin
            rdy    <= access;
            rdData <= (access && rw) ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Self-checking bench for gpio_input_ctrl (8 pins, 4-cycle debounce) using a
// scoreboard of expected bus responses.
module tb_gpio_input_ctrl;

    logic        clk;
    logic        resetN;
    logic [7:0]  GPIOIn;
    logic        cs;
    logic        as;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic        rdy;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    string       mon_tag;
    logic [31:0] mon_exp;

    gpio_input_ctrl #(
        .PIN_COUNT(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .GPIOIn(GPIOIn),
        .cs    (cs),
        .as    (as),
        .rw    (rw),
        .addr  (addr),
        .wrData(wrData),
        .rdData(rdData),
        .rdy   (rdy),
        .irq   (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access, held for one clock; writes expect a zero response word.
    task automatic applyStimulus(input bit rd, input logic [1:0] a, input logic [31:0] wd,
                                 input logic [31:0] exp, input string tag);
        cs     = 1'b1;
        as     = 1'b1;
        rw     = rd;
        addr   = a;
        wrData = wd;
        tag_q.push_back(tag);
        exp_q.push_back(rd ? exp : 32'd0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cs = 1'b0;
        as = 1'b0;
        rw = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rdy) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rdy", {31'd0, rdy}, 32'd0);
            end else begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                checkOutput(mon_tag, rdData, mon_exp);
            end
        end else begin
            checkOutput("idle_rddata", rdData, 32'd0);
        end
    end

    initial begin
        resetN = 1'b0;
        GPIOIn = 8'hFF;
        cs     = 1'b0;
        as     = 1'b0;
        rw     = 1'b1;
        addr   = 2'd0;
        wrData = 32'd0;

        // Reset with all pins high, then acceptance 6 edges after release
        repeat (3) @(negedge clk);
        checkOutput("rst_rdData", rdData, 32'd0);
        checkOutput("rst_rdy", {31'd0, rdy}, 32'd0);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        resetN = 1'b1;
        idle(5);
        applyStimulus(1, 2'd0, 32'd0, 32'h00, "rst_data_edge6");
        applyStimulus(1, 2'd0, 32'd0, 32'hFF, "rst_data_edge7");
        applyStimulus(1, 2'd3, 32'd0, 32'h00, "rst_pend");

        // Debounce: 3-cycle glitch rejected, held level accepted
        GPIOIn = 8'h00;
        idle(10);
        applyStimulus(1, 2'd0, 32'd0, 32'h00, "db_low");
        GPIOIn = 8'h01;
        idle(3);
        GPIOIn = 8'h00;
        idle(8);
        applyStimulus(1, 2'd0, 32'd0, 32'h00, "db_glitch");
        GPIOIn = 8'h01;
        idle(5);
        applyStimulus(1, 2'd0, 32'd0, 32'h00, "db_before");
        applyStimulus(1, 2'd0, 32'd0, 32'h01, "db_after");

        // Interrupt enables, pending and write-1-to-clear
        applyStimulus(0, 2'd1, 32'h01, 32'd0, "wr_rise");
        applyStimulus(0, 2'd2, 32'h02, 32'd0, "wr_fall");
        applyStimulus(1, 2'd1, 32'd0, 32'h01, "rd_rise");
        applyStimulus(1, 2'd2, 32'd0, 32'h02, "rd_fall");
        GPIOIn = 8'h02;
        idle(8);
        applyStimulus(1, 2'd3, 32'd0, 32'h00, "pend_disabled_edges");
        GPIOIn = 8'h01;
        idle(8);
        checkOutput("irq_set", {31'd0, irq}, 32'd1);
        applyStimulus(1, 2'd3, 32'd0, 32'h03, "pend_both");
        applyStimulus(0, 2'd3, 32'h01, 32'd0, "w1c_bit0");
        applyStimulus(1, 2'd3, 32'd0, 32'h02, "pend_after_w1c0");
        checkOutput("irq_still", {31'd0, irq}, 32'd1);
        applyStimulus(0, 2'd3, 32'h02, 32'd0, "w1c_bit1");
        checkOutput("irq_cleared", {31'd0, irq}, 32'd0);
        applyStimulus(1, 2'd3, 32'd0, 32'h00, "pend_empty");

        // Set wins over W1C on the accepting edge; other bits still clear
        GPIOIn = 8'h02;
        idle(8);
        GPIOIn = 8'h00;
        idle(8);
        applyStimulus(1, 2'd3, 32'd0, 32'h02, "pend_pin1_fall");
        GPIOIn = 8'h01;
        idle(5);
        applyStimulus(0, 2'd3, 32'h03, 32'd0, "w1c_collide");
        applyStimulus(1, 2'd3, 32'd0, 32'h01, "pend_collide");
        checkOutput("irq_collide", {31'd0, irq}, 32'd1);
        applyStimulus(0, 2'd3, 32'h01, 32'd0, "w1c_plain");
        applyStimulus(1, 2'd3, 32'd0, 32'h00, "pend_plain");

        // Back-to-back reads, idle response, read-only DATA
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            case (i)
                0: e = 32'h01;
                1: e = 32'h01;
                2: e = 32'h02;
                default: e = 32'h00;
            endcase
            applyStimulus(1, 2'(i), 32'd0, e, $sformatf("b2b_rd%0d", i));
            checkOutput("b2b_rdy", {31'd0, rdy}, 32'd1);
        end
        idle(1);
        checkOutput("idle_rdy", {31'd0, rdy}, 32'd0);
        applyStimulus(0, 2'd0, 32'h55, 32'd0, "wr_data_ro");
        applyStimulus(1, 2'd0, 32'd0, 32'h01, "data_unchanged");

        // Asynchronous reset between edges with PENDING = 03
        GPIOIn = 8'h02;
        idle(8);
        GPIOIn = 8'h01;
        idle(8);
        applyStimulus(1, 2'd3, 32'd0, 32'h03, "pend_pre_reset");
        idle(1);
        checkOutput("irq_pre_reset", {31'd0, irq}, 32'd1);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("async_irq", {31'd0, irq}, 32'd0);
        checkOutput("async_rdy", {31'd0, rdy}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        applyStimulus(1, 2'd1, 32'd0, 32'h00, "post_rst_rise");
        applyStimulus(1, 2'd2, 32'd0, 32'h00, "post_rst_fall");
        applyStimulus(1, 2'd3, 32'd0, 32'h00, "post_rst_pend");

        idle(3);
        checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
